// File: rtl/seq_det_param.sv
// seq_det_param: run-time loadable serial sequence detector.
// A pattern of 1..MAX_LEN bits is shifted in MSB first while 'load' is held,
// then the din stream is compared against it through a sliding window.
// Each hit gives a one-cycle 'match' pulse and bumps a saturating counter.
module seq_det_param #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             din,
    input  logic             din_valid,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    input  logic             clear,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DETECT = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state;
    state_t             state_nxt;

    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] pat_nxt;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] cmp_mask;

    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_q_nxt;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   load_cnt;
    logic [LEN_W-1:0]   load_cnt_nxt;
    logic [LEN_W-1:0]   fill_cnt;
    logic [LEN_W-1:0]   fill_cnt_nxt;
    logic [LEN_W-1:0]   fill_sat;

    // One extra bit so the +1 can never wrap, even when MAX_LEN = 2**LEN_W-1.
    logic [LEN_W:0]     load_inc;
    logic [LEN_W:0]     fill_inc;

    logic               ovl_q;
    logic               ovl_q_nxt;
    logic               match_nxt;
    logic [CNT_W-1:0]   match_cnt_nxt;
    logic               hit;

    assign armed = (state == DETECT);

    // Clamp the requested length: 0 or anything above MAX_LEN means MAX_LEN.
    always_comb begin
        len_clamped = len;
        if ((len == '0) || (len > MAX_LEN_L)) begin
            len_clamped = MAX_LEN_L;
        end
    end

    // Window compare: only the low len_q bits of the updated history and
    // the pattern take part; the window must also hold len_q fresh bits.
    always_comb begin
        hist_shift = {hist[MAX_LEN-2:0], din};
        cmp_mask   = ~({MAX_LEN{1'b1}} << len_q);
        load_inc   = {1'b0, load_cnt} + 1'b1;
        fill_inc   = {1'b0, fill_cnt} + 1'b1;
        fill_sat   = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
        hit        = (state == DETECT) && din_valid
                     && (fill_inc >= {1'b0, len_q})
                     && (((hist_shift ^ pat) & cmp_mask) == '0);
    end

    // Next-state and next-datapath logic; priority is load > clear > detect.
    always_comb begin
        state_nxt     = state;
        pat_nxt       = pat;
        hist_nxt      = hist;
        len_q_nxt     = len_q;
        load_cnt_nxt  = load_cnt;
        fill_cnt_nxt  = fill_cnt;
        ovl_q_nxt     = ovl_q;
        match_nxt     = 1'b0;
        match_cnt_nxt = match_cnt;

        if (load && (state != LOAD)) begin
            // First load cycle, either from IDLE or as a restart from DETECT.
            len_q_nxt     = len_clamped;
            pat_nxt       = '0;
            load_cnt_nxt  = '0;
            fill_cnt_nxt  = '0;
            match_cnt_nxt = '0;
            state_nxt     = LOAD;
            if (din_valid) begin
                pat_nxt      = {{(MAX_LEN-1){1'b0}}, din};
                load_cnt_nxt = ONE_L;
                if (len_clamped == ONE_L) begin
                    state_nxt = DETECT;
                    ovl_q_nxt = overlap;
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    if (!load) begin
                        // Early release: drop the partial pattern and disarm.
                        state_nxt = IDLE;
                    end else if (din_valid) begin
                        pat_nxt      = {pat[MAX_LEN-2:0], din};
                        load_cnt_nxt = load_inc[LEN_W-1:0];
                        if (load_inc == {1'b0, len_q}) begin
                            state_nxt = DETECT;
                            ovl_q_nxt = overlap;
                        end
                    end
                end
                DETECT: begin
                    if (din_valid) begin
                        hist_nxt     = hist_shift;
                        fill_cnt_nxt = fill_sat;
                        if (hit) begin
                            match_nxt = 1'b1;
                            if (match_cnt != CNT_MAX) begin
                                match_cnt_nxt = match_cnt + 1'b1;
                            end
                            if (!ovl_q) begin
                                fill_cnt_nxt = '0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase

            if (clear) begin
                match_cnt_nxt = '0;
                fill_cnt_nxt  = '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: pattern, history, counters and the match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat       <= '0;
            hist      <= '0;
            len_q     <= MAX_LEN_L;
            load_cnt  <= '0;
            fill_cnt  <= '0;
            ovl_q     <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            pat       <= pat_nxt;
            hist      <= hist_nxt;
            len_q     <= len_q_nxt;
            load_cnt  <= load_cnt_nxt;
            fill_cnt  <= fill_cnt_nxt;
            ovl_q     <= ovl_q_nxt;
            match     <= match_nxt;
            match_cnt <= match_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed scenarios plus randomized load/stream traffic,
// checked every cycle against a queue-based reference model. Two instances
// share the inputs: an 8-bit counter one and a 4-bit one for saturation.
module tb_seq_det_param;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic             din;
    logic             din_valid;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic             clear;

    logic             armed;
    logic             match;
    logic [7:0]       match_cnt;
    logic             armed_s;
    logic             match_s;
    logic [3:0]       match_cnt_s;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    // Reference model state: pattern and recent stream bits kept as queues.
    int m_mode;
    int m_len;
    int m_cnt;
    bit m_ovl;
    bit m_match;
    bit m_pat[$];
    bit m_win[$];

    seq_det_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .din_valid(din_valid),
        .len(len), .overlap(overlap), .clear(clear),
        .armed(armed), .match(match), .match_cnt(match_cnt)
    );

    seq_det_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .load(load), .din(din), .din_valid(din_valid),
        .len(len), .overlap(overlap), .clear(clear),
        .armed(armed_s), .match(match_s), .match_cnt(match_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode  = 0;
        m_len   = MAX_LEN;
        m_cnt   = 0;
        m_ovl   = 1'b0;
        m_match = 1'b0;
        m_pat.delete();
        m_win.delete();
    endtask

    // One clock edge of the behavioural model (mode 0 idle, 1 loading, 2 armed).
    task automatic modelStep(input bit ld, input bit d, input bit dv, input int ln,
                             input bit ov, input bit clr);
        bit same;
        m_match = 1'b0;
        if (ld && (m_mode != 1)) begin
            m_len = ((ln == 0) || (ln > MAX_LEN)) ? MAX_LEN : ln;
            m_pat.delete();
            m_win.delete();
            m_cnt = 0;
            if (dv) m_pat.push_back(d);
            if (dv && (m_len == 1)) begin
                m_mode = 2;
                m_ovl  = ov;
            end else begin
                m_mode = 1;
            end
        end else begin
            if (m_mode == 1) begin
                if (!ld) begin
                    m_mode = 0;
                end else if (dv) begin
                    m_pat.push_back(d);
                    if (m_pat.size() == m_len) begin
                        m_mode = 2;
                        m_ovl  = ov;
                    end
                end
            end else if ((m_mode == 2) && dv) begin
                m_win.push_back(d);
                if (m_win.size() > m_len) void'(m_win.pop_front());
                if (m_win.size() == m_len) begin
                    same = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        if (m_win[i] != m_pat[i]) same = 1'b0;
                    end
                    if (same) begin
                        m_match = 1'b1;
                        m_cnt++;
                        if (!m_ovl) m_win.delete();
                    end
                end
            end
            if (clr) begin
                m_cnt = 0;
                m_win.delete();
            end
        end
    endtask

    task automatic compareAll();
        int exp8;
        int exp4;
        exp8 = (m_cnt > 255) ? 255 : m_cnt;
        exp4 = (m_cnt > 15) ? 15 : m_cnt;
        checkOutput("armed", armed, (m_mode == 2));
        checkOutput("match", match, m_match);
        checkOutput("match_cnt", match_cnt, exp8);
        checkOutput("armed_sat", armed_s, (m_mode == 2));
        checkOutput("match_sat", match_s, m_match);
        checkOutput("match_cnt_sat", match_cnt_s, exp4);
        if (match) pulse_cnt++;
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on the
    // rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input bit ld, input bit d, input bit dv,
                                 input logic [LEN_W-1:0] ln, input bit ov, input bit clr);
        load      = ld;
        din       = d;
        din_valid = dv;
        len       = ln;
        overlap   = ov;
        clear     = clr;
        @(posedge clk);
        modelStep(ld, d, dv, int'(ln), ov, clr);
        @(negedge clk);
        compareAll();
    endtask

    task automatic loadPattern(input logic [15:0] pv, input int nbits,
                               input logic [LEN_W-1:0] lv, input bit ov);
        for (int i = nbits - 1; i >= 0; i--) begin
            applyStimulus(1'b1, pv[i], 1'b1, lv, ov, 1'b0);
        end
    endtask

    task automatic streamBits(input logic [31:0] bits, input int n, input bit ov, input bit bubbles);
        for (int i = n - 1; i >= 0; i--) begin
            if (bubbles) applyStimulus(1'b0, 1'b1, 1'b0, '0, ov, 1'b0);
            applyStimulus(1'b0, bits[i], 1'b1, '0, ov, 1'b0);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must drop at once.
    task automatic midReset();
        load      = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clear     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        compareAll();
        checkOutput("rst_armed_now", armed, 0);
        checkOutput("rst_cnt_now", match_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pv;
        logic [LEN_W-1:0] lv;
        int eff;
        int nb;
        int sent;
        int pos;
        int n;
        bit ov;
        bit dv;
        bit b;

        rst       = 1'b1;
        load      = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        len       = '0;
        overlap   = 1'b0;
        clear     = 1'b0;
        modelReset();
        @(negedge clk);
        compareAll();
        rst = 1'b0;

        $display("[TB] basic hit, len 8 pattern 10110001");
        pulse_cnt = 0;
        loadPattern(16'h00B1, 8, 5'd8, 1'b0);
        streamBits(32'b0101100010, 10, 1'b0, 1'b0);
        checkOutput("basic_pulses", pulse_cnt, 1);
        checkOutput("basic_cnt", match_cnt, 1);

        $display("[TB] overlap on / off, len 3 pattern 101");
        pulse_cnt = 0;
        loadPattern(16'h0005, 3, 5'd3, 1'b1);
        streamBits(32'b10101, 5, 1'b1, 1'b0);
        checkOutput("ovl_pulses", pulse_cnt, 2);
        checkOutput("ovl_cnt", match_cnt, 2);
        pulse_cnt = 0;
        loadPattern(16'h0005, 3, 5'd3, 1'b0);
        streamBits(32'b10101, 5, 1'b0, 1'b0);
        checkOutput("novl_pulses", pulse_cnt, 1);
        checkOutput("novl_cnt", match_cnt, 1);

        $display("[TB] len 0 clamp with valid bubbles");
        pulse_cnt = 0;
        loadPattern(16'hA5C3, 16, 5'd0, 1'b0);
        streamBits(32'h0000A5C3, 16, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("clamp_pulses", pulse_cnt, 1);

        $display("[TB] abort mid-load, then len 1");
        pulse_cnt = 0;
        for (int i = 7; i >= 4; i--) applyStimulus(1'b1, pv[0] ^ 1'b1 ? 1'b1 : 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        streamBits(32'h0000B1B1, 16, 1'b0, 1'b0);
        checkOutput("abort_pulses", pulse_cnt, 0);
        checkOutput("abort_armed", armed, 0);
        pulse_cnt = 0;
        loadPattern(16'h0001, 1, 5'd1, 1'b0);
        streamBits(32'b10110111, 8, 1'b0, 1'b0);
        checkOutput("len1_pulses", pulse_cnt, 6);

        $display("[TB] saturation and clear");
        loadPattern(16'h0001, 1, 5'd1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        checkOutput("sat_cnt8", match_cnt, 20);
        checkOutput("sat_cnt4", match_cnt_s, 15);
        applyStimulus(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
        checkOutput("clr_hit_match", match, 1);
        checkOutput("clr_hit_cnt", match_cnt, 0);

        $display("[TB] async reset mid-load and mid-detect");
        for (int i = 7; i >= 5; i--) applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        midReset();
        pulse_cnt = 0;
        streamBits(32'h0000B1B1, 16, 1'b0, 1'b0);
        checkOutput("rst_load_pulses", pulse_cnt, 0);
        loadPattern(16'h0005, 3, 5'd3, 1'b1);
        streamBits(32'b10, 2, 1'b1, 1'b0);
        midReset();
        pulse_cnt = 0;
        streamBits(32'b10101, 5, 1'b1, 1'b0);
        checkOutput("rst_det_pulses", pulse_cnt, 0);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 40; it++) begin
            ov  = 1'($urandom_range(0, 1));
            lv  = LEN_W'($urandom_range(0, 20));
            eff = ((lv == 0) || (lv > MAX_LEN)) ? MAX_LEN : int'(lv);
            pv  = 16'($urandom);
            nb  = ($urandom_range(0, 9) == 0) ? eff / 2 : eff;
            sent = 0;
            while (sent < nb) begin
                dv = ($urandom_range(0, 3) != 0);
                applyStimulus(1'b1, pv[eff-1-sent], dv,
                              (sent == 0) ? lv : LEN_W'($urandom), ov, 1'b0);
                if (dv) sent++;
            end
            pos = 0;
            n = $urandom_range(10, 40);
            for (int j = 0; j < n; j++) begin
                dv = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 4) == 0) b = 1'($urandom_range(0, 1));
                else b = pv[eff-1-(pos % eff)];
                if (dv) pos++;
                applyStimulus(1'b0, b, dv, LEN_W'($urandom), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 29) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
